// File: rtl/tone_bank.sv
// tone_bank: multi-voice phase-accumulator tone generator.
//
// Each of N_CH voices holds a phase accumulator that advances by a
// programmable increment modulo MOD every clock while the voice is busy.
// The square-wave output of a voice is high while the accumulator sits in
// the upper half of its range. A shared prescaler produces a duration tick
// every PRESCALE clocks. Timed notes count that tick down and expire with
// a one-cycle done pulse.
//
// Ports:
//   clk_in   - system clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset
//   wr_en    - single-cycle write strobe
//   wr_ch    - target voice of the write
//   wr_inc   - phase increment (0 stops the voice, >= MOD is rejected)
//   wr_dur   - note length in ticks, 0 plays until stopped
//   tone_out - per-voice square wave (registered)
//   busy     - per-voice playing flag
//   done     - per-voice one-cycle pulse when a timed note expires
//   mix_out  - population count of tone_out, one cycle behind it
module tone_bank #(
  parameter int              N_CH     = 4,
  parameter int              ACC_W    = 32,
  parameter longint unsigned MOD      = 64'd1000000000,
  parameter int              DUR_W    = 16,
  parameter int              PRESCALE = 50000,
  localparam int             CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int             MIX_W    = $clog2(N_CH + 1)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ACC_W-1:0]  wr_inc,
  input  logic [DUR_W-1:0]  wr_dur,
  output logic [N_CH-1:0]   tone_out,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   done,
  output logic [MIX_W-1:0]  mix_out
);

  localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [ACC_W:0]   MOD_V   = (ACC_W + 1)'(MOD);
  localparam logic [ACC_W-1:0] HALF_V  = ACC_W'(MOD / 64'd2);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  // Number of set bits in a voice vector.
  function automatic logic [MIX_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [MIX_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) begin
      n = n + MIX_W'(v[i]);
    end
    return n;
  endfunction

  logic [PS_W-1:0]  ps_r;
  logic             tick_s;
  logic             wr_ok_s;

  logic [ACC_W-1:0] acc_r   [N_CH];
  logic [ACC_W-1:0] inc_r   [N_CH];
  logic [DUR_W-1:0] rem_r   [N_CH];
  logic [N_CH-1:0]  busy_r;
  logic [N_CH-1:0]  tone_r;
  logic [N_CH-1:0]  done_r;
  logic [MIX_W-1:0] mix_r;

  logic [ACC_W-1:0] wrap_s   [N_CH];
  logic [ACC_W-1:0] acc_nxt  [N_CH];
  logic [ACC_W-1:0] inc_nxt  [N_CH];
  logic [DUR_W-1:0] rem_nxt  [N_CH];
  logic [N_CH-1:0]  busy_nxt;
  logic [N_CH-1:0]  tone_nxt;
  logic [N_CH-1:0]  done_nxt;

  assign tick_s = (ps_r == PS_LAST);
  // Out-of-range channels never match a voice index below, so only the
  // increment needs an explicit range check here.
  assign wr_ok_s = wr_en && ({1'b0, wr_inc} < MOD_V);

  // Free-running duration prescaler, not synchronised to writes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ps_r <= '0;
    end else if (tick_s) begin
      ps_r <= '0;
    end else begin
      ps_r <= ps_r + PS_W'(1);
    end
  end

  // Modular phase advance; both operands are below MOD so one subtraction
  // is enough and the extra bit keeps the sum from overflowing.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      logic [ACC_W:0] sum;
      sum = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
      if (sum >= MOD_V) begin
        wrap_s[i] = ACC_W'(sum - MOD_V);
      end else begin
        wrap_s[i] = ACC_W'(sum);
      end
    end
  end

  // Per-voice next state: a write overrides the tick, an expiring tick
  // overrides the phase advance.
  always_comb begin
    busy_nxt = busy_r;
    tone_nxt = tone_r;
    done_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc_nxt[i] = acc_r[i];
      inc_nxt[i] = inc_r[i];
      rem_nxt[i] = rem_r[i];
      if (wr_ok_s && (wr_ch == CH_W'(i))) begin
        acc_nxt[i]  = '0;
        tone_nxt[i] = 1'b0;
        if (wr_inc != '0) begin
          inc_nxt[i]  = wr_inc;
          rem_nxt[i]  = wr_dur;
          busy_nxt[i] = 1'b1;
        end else begin
          busy_nxt[i] = 1'b0;
        end
      end else if (busy_r[i]) begin
        if (tick_s && (rem_r[i] == DUR_W'(1))) begin
          rem_nxt[i]  = '0;
          acc_nxt[i]  = '0;
          tone_nxt[i] = 1'b0;
          busy_nxt[i] = 1'b0;
          done_nxt[i] = 1'b1;
        end else begin
          acc_nxt[i]  = wrap_s[i];
          tone_nxt[i] = (wrap_s[i] >= HALF_V);
          if (tick_s && (rem_r[i] != '0)) begin
            rem_nxt[i] = rem_r[i] - DUR_W'(1);
          end else begin
            rem_nxt[i] = rem_r[i];
          end
        end
      end else begin
        acc_nxt[i]  = acc_r[i];
        tone_nxt[i] = tone_r[i];
      end
    end
  end

  // Voice state and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_r[i] <= '0;
        inc_r[i] <= '0;
        rem_r[i] <= '0;
      end
      busy_r <= '0;
      tone_r <= '0;
      done_r <= '0;
      mix_r  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        acc_r[i] <= acc_nxt[i];
        inc_r[i] <= inc_nxt[i];
        rem_r[i] <= rem_nxt[i];
      end
      busy_r <= busy_nxt;
      tone_r <= tone_nxt;
      done_r <= done_nxt;
      mix_r  <= popcount(tone_r);
    end
  end

  assign tone_out = tone_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign mix_out  = mix_r;

endmodule

// File: tb/tb_tone_bank.sv
// Directed self-checking bench for tone_bank with MOD=100, PRESCALE=4,
// N_CH=3, ACC_W=8, DUR_W=4. Inputs change 1 time unit after a rising edge;
// outputs are sampled at the same point. cyc counts rising edges since the
// last reset release, so the DUT prescaler value equals cyc % 4.
module tb_tone_bank;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_inc;
  logic [3:0] wr_dur;
  logic [2:0] tone_out;
  logic [2:0] busy;
  logic [2:0] done;
  logic [1:0] mix_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int exp_t0 [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  int exp_m0 [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int exp_t1 [7] = '{0, 1, 1, 0, 1, 1, 0};
  int exp_m1 [7] = '{0, 0, 1, 1, 0, 1, 1};

  tone_bank #(
    .N_CH(3), .ACC_W(8), .MOD(64'd100), .DUR_W(4), .PRESCALE(4)
  ) dut (
    .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_inc(wr_inc), .wr_dur(wr_dur), .tone_out(tone_out), .busy(busy),
    .done(done), .mix_out(mix_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] inc, input logic [3:0] dur);
    wr_en  = 1'b1;
    wr_ch  = ch;
    wr_inc = inc;
    wr_dur = dur;
    step();
    wr_en  = 1'b0;
    wr_ch  = 2'd0;
    wr_inc = 8'd0;
    wr_dur = 4'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int fall_at;
    int done_at;
    int done_cnt;

    rst = 1'b1; wr_en = 1'b0; wr_ch = 2'd0; wr_inc = 8'd0; wr_dur = 4'd0;
    step(); step();
    chk("rst_tone", 32'(tone_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mix",  32'(mix_out), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // ch0 inc=25 continuous: acc 25,50,75,0 -> tone 0,1,1,0
    wr(2'd0, 8'd25, 4'd0);
    chk("c0_load_busy", 32'(busy), 32'd1);
    chk("c0_load_tone", 32'(tone_out), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("c0_tone", 32'(tone_out), 32'(exp_t0[k]));
      chk("c0_mix",  32'(mix_out),  32'(exp_m0[k]));
    end
    for (int k = 0; k < 12; k++) begin
      step();
      chk("c0_nodone", 32'(done), 32'd0);
    end
    chk("c0_still_busy", 32'(busy), 32'd1);

    // Acc is 0 after 20 steps; three more give 75 with tone and mix high.
    step(); step(); step();
    chk("pre_rst_tone", 32'(tone_out), 32'd1);
    chk("pre_rst_mix",  32'(mix_out),  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tone", 32'(tone_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_mix",  32'(mix_out), 32'd0);
    step();
    rst = 1'b0;
    cyc = 0;
    step(); step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_tone", 32'(tone_out), 32'd0);

    // ch1 inc=30: acc 30,60,90,20,50,80,10
    wr(2'd1, 8'd30, 4'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("c1_tone", 32'(tone_out), 32'(exp_t1[k] * 2));
      chk("c1_mix",  32'(mix_out),  32'(exp_m1[k]));
    end
    wr(2'd1, 8'd0, 4'd0);
    chk("c1_stop_busy", 32'(busy), 32'd0);
    chk("c1_stop_tone", 32'(tone_out), 32'd0);
    step();
    chk("c1_stop_done", 32'(done), 32'd0);

    // Invalid writes leave ch0 running undisturbed, other voices idle.
    wr(2'd0, 8'd25, 4'd0);
    wr(2'd0, 8'd100, 4'd5);
    wr(2'd3, 8'd10, 4'd0);
    chk("inv_tone", 32'(tone_out), 32'd1);
    chk("inv_busy", 32'(busy), 32'd1);
    step(); step();
    chk("inv_wrap_tone", 32'(tone_out), 32'd0);
    chk("inv_wrap_busy", 32'(busy), 32'd1);
    step(); step();
    // Acc is 50 here; rewriting restarts the phase at 0.
    wr(2'd0, 8'd25, 4'd0);
    chk("rewr_tone0", 32'(tone_out), 32'd0);
    step(); step();
    chk("rewr_tone50", 32'(tone_out), 32'd1);
    wr(2'd0, 8'd0, 4'd0);
    chk("stop0_busy", 32'(busy), 32'd0);
    chk("stop0_tone", 32'(tone_out), 32'd0);
    chk("stop0_done", 32'(done), 32'd0);
    step();
    chk("stop0_done2", 32'(done), 32'd0);

    // ch2 inc=10 dur=3 written so the prescaler reads 3 right after the
    // write: ticks at 1,5,9 cycles later, expiry at the 9th.
    while ((cyc % 4) != 2) step();
    wr(2'd2, 8'd10, 4'd3);
    fall_at  = 0;
    done_at  = 0;
    done_cnt = 0;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (done[2]) begin
        done_cnt = done_cnt + 1;
        done_at  = n;
      end
      if ((fall_at == 0) && !busy[2]) fall_at = n;
      if (n == 8) chk("dur_tone80", 32'(tone_out), 32'd4);
    end
    chk("dur_fall", 32'(fall_at), 32'd9);
    chk("dur_done_cnt", 32'(done_cnt), 32'd1);
    chk("dur_done_at", 32'(done_at), 32'd9);
    chk("dur_tone_after", 32'(tone_out), 32'd0);

    // Three voices inc=50 brought into phase (period 2).
    wr(2'd0, 8'd50, 4'd0);
    step();
    wr(2'd1, 8'd50, 4'd0);
    step();
    wr(2'd2, 8'd50, 4'd0);
    chk("lock_load", 32'(tone_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lock_tone", 32'(tone_out), (k % 2 == 0) ? 32'd7 : 32'd0);
      chk("lock_mix",  32'(mix_out),  (k % 2 == 0) ? 32'd0 : 32'd3);
    end

    // ch0 dur=1 would expire on a tick; a rewrite on that same tick wins.
    while ((cyc % 4) != 0) step();
    wr(2'd0, 8'd50, 4'd1);
    step(); step();
    wr(2'd0, 8'd50, 4'd1);
    chk("wt_busy", 32'(busy), 32'd7);
    chk("wt_done", 32'(done), 32'd0);
    step(); step(); step();
    chk("wt_busy3", 32'(busy), 32'd7);
    step();
    chk("wt_expire_done", 32'(done), 32'd1);
    chk("wt_expire_busy", 32'(busy), 32'd6);
    step();
    chk("wt_done_clear", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
